// File: rtl/rv32i_wb_arbiter.sv
// Write-back arbiter for the integer register file: round-robin between the ALU (A)
// and load unit (B), a registered write port, and a pending-write scoreboard for RAW stalls.
module rv32i_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [$clog2(NREG)-1:0] a_rd,
  input  logic [XLEN-1:0]         a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [$clog2(NREG)-1:0] b_rd,
  input  logic [XLEN-1:0]         b_data,
  input  logic                    iss_valid,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  input  logic [$clog2(NREG)-1:0] chk_rs1,
  input  logic [$clog2(NREG)-1:0] chk_rs2,
  output logic                    stall,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [NREG-1:0]         pend
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  last_t           lg;
  last_t           lg_next;
  logic            grant_a;
  logic            grant_b;
  logic [NREG-1:0] pend_next;

  // Ties go to whichever requester did not win last; no grants while in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    lg_next = lg;
    if (!rst) begin
      if (a_valid && b_valid) begin
        if (lg == LAST_B) grant_a = 1'b1;
        else              grant_b = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    if (grant_a)      lg_next = LAST_A;
    else if (grant_b) lg_next = LAST_B;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Set is applied after clear so a same-edge reissue keeps the bit high.
  always_comb begin
    pend_next = pend;
    if (rf_we) pend_next[rf_waddr] = 1'b0;
    if (iss_valid && (iss_rd != '0)) pend_next[iss_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  assign stall = ((chk_rs1 != '0) && pend[chk_rs1]) ||
                 ((chk_rs2 != '0) && pend[chk_rs2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      lg       <= LAST_B;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pend     <= '0;
    end else begin
      lg    <= lg_next;
      rf_we <= (grant_a && (a_rd != '0)) || (grant_b && (b_rd != '0));
      if (grant_a) begin
        rf_waddr <= a_rd;
        rf_wdata <= a_data;
      end else if (grant_b) begin
        rf_waddr <= b_rd;
        rf_wdata <= b_data;
      end
      pend <= pend_next;
    end
  end

endmodule
